// File: rtl/wb4_sram_pkg.sv
// wb4_sram_pkg: shared types and helpers for the Wishbone B4 SRAM slave.
//   state_t    - controller states (IDLE / ACCESS / RECOV)
//   cnt_width  - wait-state counter width, never less than 1 bit
package wb4_sram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RECOV  = 2'd2
    } state_t;

    function automatic int cnt_width(input int rd_wait, input int wr_wait);
        int m;
        m = (rd_wait > wr_wait) ? rd_wait : wr_wait;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/wb4_sram.sv
// wb4_sram: Wishbone B4 pipelined slave driving an asynchronous SRAM.
// One request at a time: accept, wait-stated SRAM access, one-cycle ack,
// then a recovery cycle that provides write hold time / bus turnaround.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   wb4_cyc_i/stb_i/we_i    Wishbone request qualifiers
//   wb4_addr_i              byte address
//   wb4_data_i/sel_i        write data and byte lanes
//   wb4_stall_o             combinational, high whenever not IDLE
//   wb4_ack_o/data_o        registered completion and read data
//   sram_addr_o             word address
//   sram_dq_i/o, dq_oe_o    split bidirectional data bus
//   sram_ce/oe/we_n_o       active-low strobes
//   sram_be_n_o             active-low byte enables
//
// state  | meaning
// -------+---------------------------------------------------------
// IDLE   | waiting for cyc&&stb; stall low
// ACCESS | SRAM strobes active, wait-state counter running to 0
// RECOV  | strobes released, ack (unless aborted), write data held
module wb4_sram
    import wb4_sram_pkg::*;
#(
    parameter int ARCHBITSZ     = 16,
    parameter int SRAMADDRBITSZ = 18,
    parameter int RDWAIT        = 2,
    parameter int WRWAIT        = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wb4_cyc_i,
    input  logic                     wb4_stb_i,
    input  logic                     wb4_we_i,
    input  logic [ARCHBITSZ-1:0]     wb4_addr_i,
    input  logic [ARCHBITSZ-1:0]     wb4_data_i,
    input  logic [ARCHBITSZ/8-1:0]   wb4_sel_i,
    output logic                     wb4_stall_o,
    output logic                     wb4_ack_o,
    output logic [ARCHBITSZ-1:0]     wb4_data_o,
    output logic [SRAMADDRBITSZ-1:0] sram_addr_o,
    input  logic [ARCHBITSZ-1:0]     sram_dq_i,
    output logic [ARCHBITSZ-1:0]     sram_dq_o,
    output logic                     sram_dq_oe_o,
    output logic                     sram_ce_n_o,
    output logic                     sram_oe_n_o,
    output logic                     sram_we_n_o,
    output logic [ARCHBITSZ/8-1:0]   sram_be_n_o
);

    localparam int BYTES = ARCHBITSZ / 8;
    localparam int OFS   = $clog2(BYTES);
    localparam int CNTW  = cnt_width(RDWAIT, WRWAIT);
    // Byte address is zero-extended so the word slice is legal even when
    // the SRAM address is wider than the bus.
    localparam int AEXTW = ARCHBITSZ + SRAMADDRBITSZ + OFS;

    localparam logic [CNTW-1:0] RD_LOAD = CNTW'(RDWAIT);
    localparam logic [CNTW-1:0] WR_LOAD = CNTW'(WRWAIT);

    state_t          state;
    logic [CNTW-1:0] cnt;
    logic            we_q;
    logic            aborted;

    logic [AEXTW-1:0] addr_ext;
    logic             unused_addr;

    assign addr_ext    = AEXTW'(wb4_addr_i);
    assign unused_addr = ^{addr_ext[AEXTW-1:OFS+SRAMADDRBITSZ], addr_ext[OFS-1:0]};

    assign wb4_stall_o = (state != ST_IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            we_q         <= 1'b0;
            aborted      <= 1'b0;
            wb4_ack_o    <= 1'b0;
            wb4_data_o   <= '0;
            sram_addr_o  <= '0;
            sram_dq_o    <= '0;
            sram_dq_oe_o <= 1'b0;
            sram_ce_n_o  <= 1'b1;
            sram_oe_n_o  <= 1'b1;
            sram_we_n_o  <= 1'b1;
            sram_be_n_o  <= '1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (wb4_cyc_i && wb4_stb_i) begin
                        we_q         <= wb4_we_i;
                        aborted      <= 1'b0;
                        cnt          <= wb4_we_i ? WR_LOAD : RD_LOAD;
                        sram_addr_o  <= addr_ext[OFS +: SRAMADDRBITSZ];
                        sram_dq_o    <= wb4_data_i;
                        sram_be_n_o  <= ~wb4_sel_i;
                        sram_ce_n_o  <= 1'b0;
                        sram_oe_n_o  <= wb4_we_i;
                        sram_we_n_o  <= ~wb4_we_i;
                        sram_dq_oe_o <= wb4_we_i;
                        state        <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // A dropped cyc only suppresses the ack; the SRAM cycle
                    // keeps its full length so strobes are never truncated.
                    if (!wb4_cyc_i) begin
                        aborted <= 1'b1;
                    end
                    if (cnt == '0) begin
                        sram_ce_n_o <= 1'b1;
                        sram_oe_n_o <= 1'b1;
                        sram_we_n_o <= 1'b1;
                        wb4_ack_o   <= wb4_cyc_i && !aborted;
                        if (!we_q) begin
                            wb4_data_o <= sram_dq_i;
                        end
                        state <= ST_RECOV;
                    end else begin
                        cnt <= cnt - CNTW'(1);
                    end
                end
                ST_RECOV: begin
                    wb4_ack_o    <= 1'b0;
                    sram_dq_oe_o <= 1'b0;
                    aborted      <= 1'b0;
                    state        <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb4_sram.sv
// tb_wb4_sram: directed literal checks plus randomized traffic against a
// cycle-timeline model of the wb4_sram slave (ARCHBITSZ=16, RDWAIT=2, WRWAIT=1).
module tb_wb4_sram;

    localparam int RDW = 2;
    localparam int WRW = 1;

    logic        clk_i;
    logic        rst_i;
    logic        wb4_cyc_i;
    logic        wb4_stb_i;
    logic        wb4_we_i;
    logic [15:0] wb4_addr_i;
    logic [15:0] wb4_data_i;
    logic [1:0]  wb4_sel_i;
    logic        wb4_stall_o;
    logic        wb4_ack_o;
    logic [15:0] wb4_data_o;
    logic [17:0] sram_addr_o;
    logic [15:0] sram_dq_i;
    logic [15:0] sram_dq_o;
    logic        sram_dq_oe_o;
    logic        sram_ce_n_o;
    logic        sram_oe_n_o;
    logic        sram_we_n_o;
    logic [1:0]  sram_be_n_o;

    wb4_sram #(
        .ARCHBITSZ    (16),
        .SRAMADDRBITSZ(18),
        .RDWAIT       (RDW),
        .WRWAIT       (WRW)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .wb4_cyc_i   (wb4_cyc_i),
        .wb4_stb_i   (wb4_stb_i),
        .wb4_we_i    (wb4_we_i),
        .wb4_addr_i  (wb4_addr_i),
        .wb4_data_i  (wb4_data_i),
        .wb4_sel_i   (wb4_sel_i),
        .wb4_stall_o (wb4_stall_o),
        .wb4_ack_o   (wb4_ack_o),
        .wb4_data_o  (wb4_data_o),
        .sram_addr_o (sram_addr_o),
        .sram_dq_i   (sram_dq_i),
        .sram_dq_o   (sram_dq_o),
        .sram_dq_oe_o(sram_dq_oe_o),
        .sram_ce_n_o (sram_ce_n_o),
        .sram_oe_n_o (sram_oe_n_o),
        .sram_we_n_o (sram_we_n_o),
        .sram_be_n_o (sram_be_n_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int ack_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Asynchronous SRAM: reads combinational while selected, writes per lane
    // on every clock with CE and WE low. Reset reloads it from the golden copy.
    logic [15:0] sram_mem [0:255];
    logic [15:0] gold     [0:255];

    assign sram_dq_i = (!sram_ce_n_o && !sram_oe_n_o) ? sram_mem[sram_addr_o[7:0]] : 16'hDEAD;

    always @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 256; i++) sram_mem[i] <= gold[i];
        end else if (!sram_ce_n_o && !sram_we_n_o) begin
            for (int b = 0; b < 2; b++)
                if (!sram_be_n_o[b]) sram_mem[sram_addr_o[7:0]][8*b +: 8] <= sram_dq_o[8*b +: 8];
        end
    end

    // Timeline model: a transaction accepted in cycle 0 is in ACCESS for
    // cycles 1..W+1 and acks in cycle W+2; the latched address/data/lanes
    // stay on the pins until the next acceptance or reset.
    bit          model_on = 0;
    bit          busy = 0;
    int          rel = 0;
    bit          m_we = 0;
    bit          m_abort = 0;
    logic [7:0]  m_idx = 0;
    logic [17:0] h_addr = 0;
    logic [15:0] h_dq = 0;
    logic [1:0]  h_be = 2'b11;
    bit          rd_valid = 0;
    logic [15:0] rd_val = 0;

    int mw;
    bit in_acc, in_rec;

    always @(negedge clk_i) begin
        mw     = m_we ? WRW : RDW;
        in_acc = busy && rel >= 1 && rel <= mw + 1;
        in_rec = busy && rel == mw + 2;
        if (model_on) begin
            chk("stall",    wb4_stall_o,  in_acc || in_rec);
            chk("ce_n",     sram_ce_n_o,  !in_acc);
            chk("oe_n",     sram_oe_n_o,  !(in_acc && !m_we));
            chk("we_n",     sram_we_n_o,  !(in_acc && m_we));
            chk("dq_oe",    sram_dq_oe_o, m_we && (in_acc || in_rec));
            chk("ack",      wb4_ack_o,    in_rec && !m_abort);
            chk("addr",     sram_addr_o,  h_addr);
            chk("dq_o",     sram_dq_o,    h_dq);
            chk("be_n",     sram_be_n_o,  h_be);
            chk("oe_we_excl", !sram_oe_n_o && !sram_we_n_o, 1'b0);
            if (rd_valid) chk("data_o", wb4_data_o, rd_val);
            if (wb4_ack_o) ack_total++;
        end
        if (rst_i) begin
            model_on = 1;
            busy     = 0;
            m_we     = 0;
            h_addr   = 0;
            h_dq     = 0;
            h_be     = 2'b11;
            rd_valid = 1;
            rd_val   = 0;
        end else if (model_on) begin
            if (busy) begin
                if (in_acc && !wb4_cyc_i) m_abort = 1;
                if (!m_we && rel == mw + 1) begin
                    if (m_abort) rd_valid = 0;
                    else begin
                        rd_valid = 1;
                        rd_val   = gold[m_idx];
                    end
                end
                if (in_rec) busy = 0;
                else rel++;
            end else if (wb4_cyc_i && wb4_stb_i) begin
                busy    = 1;
                rel     = 1;
                m_we    = wb4_we_i;
                m_abort = 0;
                m_idx   = wb4_addr_i[8:1];
                h_addr  = 18'(wb4_addr_i >> 1);
                h_dq    = wb4_data_i;
                h_be    = ~wb4_sel_i;
                if (wb4_we_i)
                    for (int b = 0; b < 2; b++)
                        if (wb4_sel_i[b]) gold[m_idx][8*b +: 8] = wb4_data_i[8*b +: 8];
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic present(input logic we, input logic [15:0] addr, input logic [15:0] data,
                           input logic [1:0] sel);
        wb4_cyc_i  = 1'b1;
        wb4_stb_i  = 1'b1;
        wb4_we_i   = we;
        wb4_addr_i = addr;
        wb4_data_i = data;
        wb4_sel_i  = sel;
    endtask

    // Random transaction: hold the request until not stalled, optionally
    // drop cyc for one ACCESS cycle, return in the ack/recovery cycle.
    task automatic issue(input logic we, input logic [15:0] addr, input logic [15:0] data,
                         input logic [1:0] sel, input int abort_k);
        int n;
        int w;
        w = we ? WRW : RDW;
        present(we, addr, data, sel);
        n = 0;
        while (wb4_stall_o && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) begin
            errors++;
            $display("FAIL accept_timeout: stall still %0b after %0d cycles", wb4_stall_o, n);
        end
        tick();
        wb4_stb_i = 1'b0;
        for (int k = 1; k <= w + 1; k++) begin
            wb4_cyc_i = (abort_k == k) ? 1'b0 : 1'b1;
            if (k > 1 || abort_k == 1) begin end
            tick();
        end
        wb4_cyc_i = 1'b1;
    endtask

    int acks_before;

    initial begin
        for (int i = 0; i < 256; i++) gold[i] = 16'($urandom);
        gold[8] = 16'h1234;
        rst_i = 1'b1;
        wb4_cyc_i = 0; wb4_stb_i = 0; wb4_we_i = 0;
        wb4_addr_i = 0; wb4_data_i = 0; wb4_sel_i = 0;
        repeat (3) tick();
        rst_i = 1'b0;
        chk("rst_stall", wb4_stall_o, 0);
        chk("rst_ack", wb4_ack_o, 0);
        chk("rst_strobes", {sram_ce_n_o, sram_oe_n_o, sram_we_n_o}, 3'b111);
        chk("rst_be_n", sram_be_n_o, 2'b11);
        chk("rst_dq_oe", sram_dq_oe_o, 0);
        chk("rst_addr_dq_data", {sram_addr_o, sram_dq_o, wb4_data_o}, 0);
        tick();

        // Read word 0x0008 (preloaded 0x1234)
        present(1'b0, 16'h0010, 16'h0000, 2'b11);
        tick(); wb4_stb_i = 1'b0;
        chk("rd_c1_oe_n", sram_oe_n_o, 0);
        tick(); chk("rd_c2_oe_n", sram_oe_n_o, 0);
        tick(); chk("rd_c3_oe_n", sram_oe_n_o, 0); chk("rd_c3_ack", wb4_ack_o, 0);
        tick(); chk("rd_c4_ack", wb4_ack_o, 1); chk("rd_c4_data", wb4_data_o, 16'h1234);
        chk("rd_c4_oe_n", sram_oe_n_o, 1);
        tick(); chk("rd_c5_stall", wb4_stall_o, 0);
        wb4_cyc_i = 1'b0;
        tick();

        // Full write 0xBEEF to byte address 0x0010
        present(1'b1, 16'h0010, 16'hBEEF, 2'b11);
        tick(); wb4_stb_i = 1'b0;
        chk("wr_c1_addr", sram_addr_o, 18'h00008);
        chk("wr_c1_we_n", sram_we_n_o, 0); chk("wr_c1_dq_oe", sram_dq_oe_o, 1);
        tick(); chk("wr_c2_we_n", sram_we_n_o, 0); chk("wr_c2_ack", wb4_ack_o, 0);
        tick(); chk("wr_c3_we_n", sram_we_n_o, 1); chk("wr_c3_dq_oe", sram_dq_oe_o, 1);
        chk("wr_c3_ack", wb4_ack_o, 1);
        tick(); chk("wr_c4_ack", wb4_ack_o, 0); chk("wr_c4_stall", wb4_stall_o, 0);
        chk("wr_c4_dq_oe", sram_dq_oe_o, 0);
        chk("wr_data_keep", wb4_data_o, 16'h1234);

        // High-byte write
        present(1'b1, 16'h0010, 16'hA55A, 2'b10);
        tick(); wb4_stb_i = 1'b0;
        chk("bw_be_n", sram_be_n_o, 2'b01);
        repeat (3) tick();
        chk("bw_mem", sram_mem[8], 16'hA5EF);
        wb4_cyc_i = 1'b0;
        tick();

        // Bridge RMW: read then write presented in the ack cycle
        acks_before = ack_total;
        present(1'b0, 16'h0020, 16'h0000, 2'b11);
        tick(); wb4_stb_i = 1'b0;
        repeat (3) tick();
        chk("rmw_rd_ack", wb4_ack_o, 1);
        present(1'b1, 16'h0020, 16'h7E57, 2'b01);
        tick(); chk("rmw_wr_accept_stall", wb4_stall_o, 0);
        tick(); wb4_stb_i = 1'b0; chk("rmw_wr_ce_n", sram_ce_n_o, 0);
        tick(); tick(); chk("rmw_wr_ack", wb4_ack_o, 1);
        tick(); chk("rmw_ack_count", ack_total - acks_before, 2);
        wb4_cyc_i = 1'b0;
        tick();

        // Abort: cyc dropped in cycle 2 of a read
        present(1'b0, 16'h0030, 16'h0000, 2'b11);
        tick(); wb4_stb_i = 1'b0;
        tick(); wb4_cyc_i = 1'b0;
        tick(); chk("ab_c3_ce_n", sram_ce_n_o, 0); chk("ab_c3_oe_n", sram_oe_n_o, 0);
        tick(); chk("ab_c4_ack", wb4_ack_o, 0); chk("ab_c4_ce_n", sram_ce_n_o, 1);
        tick();
        present(1'b1, 16'h0040, 16'h1111, 2'b11);
        chk("ab_c5_stall", wb4_stall_o, 0);
        tick(); wb4_stb_i = 1'b0; chk("ab_c6_ce_n", sram_ce_n_o, 0);
        repeat (3) tick();
        wb4_cyc_i = 1'b0;
        tick();

        // Reset in cycle 1 of a write (no lanes, so memory is untouched)
        present(1'b1, 16'h0050, 16'hFFFF, 2'b00);
        tick(); wb4_stb_i = 1'b0; rst_i = 1'b1;
        tick(); rst_i = 1'b0;
        chk("rs_strobes", {sram_ce_n_o, sram_oe_n_o, sram_we_n_o}, 3'b111);
        chk("rs_dq_oe", sram_dq_oe_o, 0);
        chk("rs_ack", wb4_ack_o, 0);
        chk("rs_stall", wb4_stall_o, 0);
        wb4_cyc_i = 1'b0;
        tick();

        // Randomized traffic
        for (int t = 0; t < 300; t++) begin
            logic we;
            int   ab;
            we = 1'($urandom_range(0, 1));
            ab = ($urandom_range(0, 5) == 0) ? $urandom_range(1, (we ? WRW : RDW) + 1) : 0;
            issue(we, 16'($urandom_range(0, 511)), 16'($urandom), 2'($urandom_range(0, 3)), ab);
            if ($urandom_range(0, 1) == 1) begin
                wb4_stb_i = 1'b0;
                repeat ($urandom_range(1, 3)) begin
                    wb4_cyc_i = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        end
        wb4_cyc_i = 1'b0;
        wb4_stb_i = 1'b0;
        repeat (6) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
